// File: rtl/mul_cell_arbiter_if.sv
// rtl/mul_cell_arbiter_if.sv - requester, response and multiply-cell signals of mul_cell_arbiter
interface mul_cell_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_src1;
  logic [DATA_W-1:0] req0_src2;
  logic              resp0_valid;
  logic              resp0_ready;
  logic [DATA_W-1:0] resp0_result;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_src1;
  logic [DATA_W-1:0] req1_src2;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [DATA_W-1:0] resp1_result;
  logic [DATA_W-1:0] mul_src1;
  logic [DATA_W-1:0] mul_src2;
  logic [DATA_W-1:0] mul_result;
  logic              busy;

  modport slave (
    input  req0_valid, req0_src1, req0_src2, resp0_ready,
    input  req1_valid, req1_src1, req1_src2, resp1_ready,
    input  mul_result,
    output req0_ready, resp0_valid, resp0_result,
    output req1_ready, resp1_valid, resp1_result,
    output mul_src1, mul_src2, busy
  );

  modport master (
    output req0_valid, req0_src1, req0_src2, resp0_ready,
    output req1_valid, req1_src1, req1_src2, resp1_ready,
    output mul_result,
    input  req0_ready, resp0_valid, resp0_result,
    input  req1_ready, resp1_valid, resp1_result,
    input  mul_src1, mul_src2, busy
  );
endinterface

// File: rtl/mul_cell_arbiter.sv
// rtl/mul_cell_arbiter.sv - round-robin, credit-gated sharing of one pipelined multiply cell
// between two requesters, with a tag pipeline steering results into per-requester FIFOs.
module mul_cell_arbiter #(
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 1,
  parameter int RESP_DEPTH  = 2
) (
  input logic             clk,
  input logic             reset,
  mul_cell_arbiter_if.slave bus
);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int INF_W = $clog2(MUL_LATENCY + 1);

  logic                   prio_q, prio_d;
  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [MUL_LATENCY-1:0] tag_id_q, tag_id_d;
  logic [DATA_W-1:0]      mem_q [2][RESP_DEPTH];
  logic [DATA_W-1:0]      mem_d [2][RESP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q [2], wr_ptr_d [2];
  logic [PTR_W-1:0]       rd_ptr_q [2], rd_ptr_d [2];
  logic [CNT_W-1:0]       cnt_q [2], cnt_d [2];
  logic                   busy_q, busy_d;

  logic [1:0]       req_valid, resp_ready, credit, elig, gnt, push, pop;
  logic [INF_W-1:0] inflight [2];

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign resp_ready = {bus.resp1_ready, bus.resp0_ready};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == RESP_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit uses registered counts only, so a pop frees a slot one cycle later.
  always_comb begin
    inflight[0] = '0;
    inflight[1] = '0;
    credit      = '0;
    push        = '0;
    pop         = '0;
    for (int s = 0; s < MUL_LATENCY; s++) begin
      if (tag_vld_q[s]) begin
        inflight[tag_id_q[s]] = inflight[tag_id_q[s]] + INF_W'(1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      credit[i] = (int'(cnt_q[i]) + int'(inflight[i])) < RESP_DEPTH;
      pop[i]    = (cnt_q[i] != '0) && resp_ready[i];
      push[i]   = tag_vld_q[MUL_LATENCY-1] && (int'(tag_id_q[MUL_LATENCY-1]) == i);
    end
    elig = req_valid & credit & {2{~reset}};
    if (elig == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt = elig;
    end
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = |gnt;
    tag_id_d[0]  = gnt[1];
    for (int s = 1; s < MUL_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.mul_result;
        wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      end
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    busy_d = (|tag_vld_d) | (cnt_d[0] != '0) | (cnt_d[1] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '{default: '0};
      rd_ptr_q  <= '{default: '0};
      cnt_q     <= '{default: '0};
      busy_q    <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req0_ready   = gnt[0];
  assign bus.req1_ready   = gnt[1];
  assign bus.mul_src1     = gnt[1] ? bus.req1_src1 : (gnt[0] ? bus.req0_src1 : '0);
  assign bus.mul_src2     = gnt[1] ? bus.req1_src2 : (gnt[0] ? bus.req0_src2 : '0);
  assign bus.resp0_valid  = cnt_q[0] != '0;
  assign bus.resp1_valid  = cnt_q[1] != '0;
  assign bus.resp0_result = mem_q[0][rd_ptr_q[0]];
  assign bus.resp1_result = mem_q[1][rd_ptr_q[1]];
  assign bus.busy         = busy_q;

  for (genvar g = 0; g < 2; g++) begin : g_ovf
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push[g] && !pop[g] && (int'(cnt_q[g]) == RESP_DEPTH)));
  end
endmodule

// File: tb/tb_mul_cell_arbiter.sv
// tb/tb_mul_cell_arbiter.sv - scoreboard bench for mul_cell_arbiter with a registered multiply cell model
module tb_mul_cell_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul_cell_arbiter_if #(.DATA_W(32)) bus ();

  mul_cell_arbiter #(.DATA_W(32), .MUL_LATENCY(1), .RESP_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.mul_result <= bus.mul_src1 * bus.mul_src2;

  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic        s_rdy0, s_rdy1, s_rv0, s_rv1, s_busy;
  logic [31:0] s_res0, s_res1, s_msrc1;

  // One cycle: sample at negedge (scoreboard + snapshot), return 1 time unit after posedge.
  task automatic tick();
    logic [31:0] p;
    @(negedge clk);
    s_rdy0  = bus.req0_ready;
    s_rdy1  = bus.req1_ready;
    s_rv0   = bus.resp0_valid;
    s_rv1   = bus.resp1_valid;
    s_res0  = bus.resp0_result;
    s_res1  = bus.resp1_result;
    s_msrc1 = bus.mul_src1;
    s_busy  = bus.busy;
    if (bus.req0_valid && bus.req0_ready) begin
      p = bus.req0_src1 * bus.req0_src2;
      exp0.push_back(p);
    end
    if (bus.req1_valid && bus.req1_ready) begin
      p = bus.req1_src1 * bus.req1_src2;
      exp1.push_back(p);
    end
    if (bus.resp0_valid && bus.resp0_ready) begin
      checks++;
      if (exp0.size() == 0) begin
        failures++;
        $display("FAIL sb_resp0 got=%h expected=none", bus.resp0_result);
      end else begin
        p = exp0.pop_front();
        if (bus.resp0_result !== p) begin
          failures++;
          $display("FAIL sb_resp0 got=%h expected=%h", bus.resp0_result, p);
        end
      end
    end
    if (bus.resp1_valid && bus.resp1_ready) begin
      checks++;
      if (exp1.size() == 0) begin
        failures++;
        $display("FAIL sb_resp1 got=%h expected=none", bus.resp1_result);
      end else begin
        p = exp1.pop_front();
        if (bus.resp1_result !== p) begin
          failures++;
          $display("FAIL sb_resp1 got=%h expected=%h", bus.resp1_result, p);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.req0_src1   = '0;
    bus.req0_src2   = '0;
    bus.req1_src1   = '0;
    bus.req1_src2   = '0;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp0.delete();
    exp1.delete();
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_src1  = 32'd9;
    bus.req0_src2  = 32'd9;
    tick();
    checks++;
    if ({s_rdy0, s_rdy1, s_rv0, s_rv1, s_busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b expected=00000", {s_rdy0, s_rdy1, s_rv0, s_rv1, s_busy});
    end
    checks++;
    if ({s_res0, s_res1, s_msrc1} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h expected=0", s_res0, s_res1, s_msrc1);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_src1  = 32'd3;
    bus.req0_src2  = 32'd5;
    tick();
    checks++;
    if ({s_rdy0, s_busy} !== 2'b10 || s_msrc1 !== 32'd3) begin
      failures++;
      $display("FAIL single_c0 got=rdy%b busy%b src1=%0d expected=rdy1 busy0 src1=3", s_rdy0, s_busy, s_msrc1);
    end
    bus.req0_valid = 1'b0;
    tick();
    checks++;
    if ({s_rv0, s_busy} !== 2'b01) begin
      failures++;
      $display("FAIL single_c1 got=rv%b busy%b expected=rv0 busy1", s_rv0, s_busy);
    end
    tick();
    checks++;
    if ({s_rv0, s_busy} !== 2'b11 || s_res0 !== 32'd15) begin
      failures++;
      $display("FAIL single_c2 got=rv%b busy%b res=%0d expected=rv1 busy1 res=15", s_rv0, s_busy, s_res0);
    end
    tick();
    checks++;
    if ({s_rv0, s_busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_c3 got=rv%b busy%b expected=rv0 busy0", s_rv0, s_busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_src1  = 32'd1;
    bus.req0_src2  = 32'd7;
    bus.req1_src1  = 32'd100;
    bus.req1_src2  = 32'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({s_rdy1, s_rdy0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr_grant cycle=%0d got=%b expected=%b", i, {s_rdy1, s_rdy0},
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (s_rdy0) bus.req0_src1 = bus.req0_src1 + 32'd1;
      if (s_rdy1) bus.req1_src1 = bus.req1_src1 + 32'd1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
    checks++;
    if (exp0.size() + exp1.size() != 0) begin
      failures++;
      $display("FAIL rr_drain got=%0d pending expected=0", exp0.size() + exp1.size());
    end
  endtask

  task automatic test_backpressure();
    int n0;
    int g1;
    logic [31:0] ops [3];
    ops = '{32'd2, 32'd3, 32'd4};
    do_reset();
    n0              = 0;
    g1              = 0;
    bus.resp0_ready = 1'b0;
    bus.req1_valid  = 1'b1;
    bus.req1_src1   = 32'd5;
    bus.req1_src2   = 32'd5;
    bus.req0_valid  = 1'b1;
    bus.req0_src1   = ops[0];
    bus.req0_src2   = 32'd10;
    for (int i = 0; i < 20 && n0 < 2; i++) begin
      tick();
      if (s_rdy0) begin
        n0++;
        bus.req0_src1 = ops[n0];
      end
    end
    checks++;
    if (n0 != 2) begin
      failures++;
      $display("FAIL bp_accept got=%0d expected=2", n0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_rdy1) g1++;
      checks++;
      if (s_rdy0 !== 1'b0 || s_rv0 !== 1'b1 || s_res0 !== 32'd20) begin
        failures++;
        $display("FAIL bp_stall cycle=%0d got=rdy%b rv%b head=%0d expected=rdy0 rv1 head=20",
                 i, s_rdy0, s_rv0, s_res0);
      end
    end
    checks++;
    if (g1 < 3) begin
      failures++;
      $display("FAIL bp_req1_grants got=%0d expected>=3", g1);
    end
    bus.resp0_ready = 1'b1;
    n0 = 0;
    for (int i = 0; i < 10 && n0 == 0; i++) begin
      tick();
      if (s_rdy0) n0 = 1;
    end
    checks++;
    if (n0 != 1) begin
      failures++;
      $display("FAIL bp_resume got=no_accept expected=accept_40");
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
    checks++;
    if (exp0.size() + exp1.size() != 0) begin
      failures++;
      $display("FAIL bp_drain got=%0d pending expected=0", exp0.size() + exp1.size());
    end
  endtask

  task automatic test_arith();
    int seen;
    do_reset();
    seen           = 0;
    bus.req1_valid = 1'b1;
    bus.req1_src1  = 32'hFFFF_FFFF;
    bus.req1_src2  = 32'd2;
    tick();
    bus.req1_src1  = 32'h0001_0000;
    bus.req1_src2  = 32'h0001_0000;
    for (int i = 0; i < 5 && !s_rdy1; i++) tick();
    tick();
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_rv1) begin
        checks++;
        if (s_res1 !== ((seen == 0) ? 32'hFFFF_FFFE : 32'h0000_0000)) begin
          failures++;
          $display("FAIL arith_result idx=%0d got=%h expected=%h", seen, s_res1,
                   (seen == 0) ? 32'hFFFF_FFFE : 32'h0000_0000);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 2) begin
      failures++;
      $display("FAIL arith_count got=%0d expected=2", seen);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_src1  = 32'd7;
    bus.req0_src2  = 32'd6;
    tick();
    checks++;
    if (s_rdy0 !== 1'b1) begin
      failures++;
      $display("FAIL midrst_issue got=%b expected=1", s_rdy0);
    end
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp0.delete();
    exp1.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({s_rv0, s_busy} !== 2'b00) begin
        failures++;
        $display("FAIL midrst_quiet cycle=%0d got=rv%b busy%b expected=rv0 busy0", i, s_rv0, s_busy);
      end
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    checks++;
    if ({s_rdy1, s_rdy0} !== 2'b01) begin
      failures++;
      $display("FAIL midrst_prio got=%b expected=01", {s_rdy1, s_rdy0});
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
  endtask

  task automatic test_push_pop();
    do_reset();
    bus.resp0_ready = 1'b0;
    bus.req0_valid  = 1'b1;
    bus.req0_src1   = 32'd2;
    bus.req0_src2   = 32'd3;
    tick();
    bus.req0_valid  = 1'b0;
    tick();
    tick();
    bus.req0_valid  = 1'b1;
    bus.req0_src1   = 32'd4;
    bus.req0_src2   = 32'd5;
    tick();
    bus.req0_valid  = 1'b0;
    bus.resp0_ready = 1'b1;
    tick();
    checks++;
    if (s_rv0 !== 1'b1 || s_res0 !== 32'd6) begin
      failures++;
      $display("FAIL pp_before got=rv%b head=%0d expected=rv1 head=6", s_rv0, s_res0);
    end
    bus.resp0_ready = 1'b0;
    tick();
    checks++;
    if (s_rv0 !== 1'b1 || s_res0 !== 32'd20) begin
      failures++;
      $display("FAIL pp_after got=rv%b head=%0d expected=rv1 head=20", s_rv0, s_res0);
    end
    bus.resp0_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({s_rv0, s_busy} !== 2'b00 || exp0.size() != 0) begin
      failures++;
      $display("FAIL pp_empty got=rv%b busy%b pending=%0d expected=rv0 busy0 pending=0",
               s_rv0, s_busy, exp0.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    bus.mul_result = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_arith();
    test_reset_mid_op();
    test_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_cell_arbiter.md
Name: mul_cell_arbiter

Overview:
- Shares one pipelined 32x32 multiply cell (low 32 bits of the product, fixed result latency) between two requesters, e.g. the CPU mul path and a custom-instruction/accelerator port.
- Round-robin arbitration; tracks in-flight operations by tag; routes each result to a per-requester response FIFO.
- Credit-based issue, so a result is never dropped under response back-pressure.

Parameters:
- DATA_W, 32, operand and result width.
- MUL_LATENCY, 1, cycles from operands on mul_src1/2 to valid mul_result (1 for the registered-multiplier cell).
- RESP_DEPTH, 2, entries per requester response FIFO; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_src1  in  DATA_W  operand A.
- req0_src2  in  DATA_W  operand B.
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 consumes the result.
- resp0_result  out  DATA_W  product low bits.
- req1_valid / req1_ready / req1_src1 / req1_src2 / resp1_valid / resp1_ready / resp1_result: same as requester 0, for requester 1.
- mul_src1  out  DATA_W  operand A to the multiply cell.
- mul_src2  out  DATA_W  operand B to the multiply cell.
- mul_result  in  DATA_W  cell result, valid MUL_LATENCY cycles after issue.
- busy  out  1  any operation in flight or any response FIFO non-empty.

Behaviour:
- Reset (async, active-high): all flops cleared. Outputs during/after reset: req*_ready=0, resp*_valid=0, resp*_result=0, mul_src*=0, busy=0. Priority pointer = requester 0. In-flight ops and FIFO contents are discarded, including on reset mid-operation. No response is produced after reset deassertion for pre-reset requests.
- Credit: credit_i = (fifo_count_i + inflight_i) < RESP_DEPTH.
  - inflight_i counts pipeline tags with id=i.
  - A pop in the current cycle does not add credit until the next cycle (registered counts only).
- Eligibility: eligible_i = req_i_valid & credit_i.
- Grant (combinational, at most one per cycle):
  - Both eligible: grant the requester indicated by the priority pointer.
  - One eligible: grant it.
  - After any grant to i, the pointer moves to the other requester. With no grant, the pointer holds.
- req_i_ready = grant_i. The transfer occurs on valid&ready. Ready never asserts without valid.
- Issue:
  - mul_src1/2 = granted requester's operands in the grant cycle; 0 when there is no grant.
  - A tag {valid=1, id} enters a MUL_LATENCY-stage shift register.
- Return: when the last tag stage is valid, mul_result is pushed into FIFO[id] in that cycle.
  - Credit guarantees no overflow. An overflow attempt is an assertion failure in simulation.
- Response FIFO: first-word fall-through.
  - resp_i_valid = non-empty; resp_i_result = head.
  - Pop on resp_i_valid & resp_i_ready.
  - Simultaneous push and pop is allowed; count unchanged; data order preserved.
  - Pointers wrap modulo RESP_DEPTH.
- Latency: issue at cycle N → resp_valid at cycle N+MUL_LATENCY+1 (registered FIFO write) when the FIFO was empty.
- Throughput: one issue per cycle in aggregate. A single requester with resp_ready held high sustains one op/cycle only if RESP_DEPTH ≥ MUL_LATENCY+1; otherwise it is throttled by credit.
- Arithmetic: result is the low DATA_W bits of the product; identical for signed and unsigned operands; overflow silently truncates.
- busy = |inflight | |fifo_count, registered.

Test Plan:
- Only req0 valid, src1=3, src2=5, resp0_ready=1 → req0_ready=1 in cycle 0, mul_src1=3 in cycle 0, resp0_valid with result 15 in cycle 2 (MUL_LATENCY=1); busy high in cycles 1-2.
- Both requesters valid continuously, resp ready=1 → grants alternate 0,1,0,1, starting with 0 after reset; each requester's results arrive in issue order.
- resp0_ready=0, req0 streams 2,3,4 times 10 → two ops accepted (RESP_DEPTH=2), then req0_ready=0 while req1 is still granted every cycle; raising resp0_ready pops 20, 30 and then 40 is accepted.
- req1 src1=0xFFFFFFFF, src2=2 → resp1_result=0xFFFFFFFE; src1=0x00010000, src2=0x00010000 → 0x00000000.
- Assert reset one cycle after issuing 7*6 → no resp0_valid after release, busy=0, priority back to requester 0.
- Push and pop in the same cycle on a FIFO holding one entry → count stays 1; head advances to the newer result.
